seg7_scan_reader: RTL and testbench

SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

---
 rtl/seg7_scan_reader.sv | 178 +++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_reader.sv
// Recovers the four digits shown on a multiplexed, active-low 7-segment display.
// Each digit must be stable for STABLE_CYCLES before it is captured, then the full frame is converted to binary.
module seg7_scan_reader #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  an_n,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [13:0] value,
    output logic        frame_valid,
    output logic        seg_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {COLLECT, CONVERT} state_e;

    state_e      state_q;
    logic [6:0]  seg_q, segPrev_q;
    logic [3:0]  an_q, anPrev_q;
    logic [7:0]  stableCnt_q, stableCnt_d;
    logic [3:0]  mask_q;
    logic        errFlag_q, convErr_q;
    logic [TW-1:0] timer_q;
    logic [15:0] shadowNib_q;
    logic [3:0]  shadowBlank_q;
    logic [13:0] acc_q, acc_d;
    logic [1:0]  idx_q;
    logic [15:0] digits_q;
    logic [3:0]  blank_q;
    logic [13:0] value_q;
    logic        frameValid_q, segErr_q;

    logic        oneHot, stableHit, captureHit, capture;
    logic [1:0]  capIdx;
    logic [3:0]  capBit, maskNext;
    logic [3:0]  decNib, convNib, convDigit;
    logic        decBlank, decErr;

    assign oneHot     = $onehot(~an_q);
    assign stableHit  = oneHot && (an_q == anPrev_q) && (seg_q == segPrev_q);
    assign captureHit = stableHit && (stableCnt_q == 8'(STABLE_CYCLES - 2));
    assign capture    = captureHit && (state_q == COLLECT);
    assign capBit     = ~an_q;
    assign maskNext   = mask_q | capBit;

    // Saturate at STABLE_CYCLES-1 so one stable period yields exactly one capture.
    always_comb begin
        stableCnt_d = 8'd0;
        if (stableHit) begin
            if (stableCnt_q == 8'(STABLE_CYCLES - 1))
                stableCnt_d = stableCnt_q;
            else
                stableCnt_d = stableCnt_q + 8'd1;
        end
    end

    always_comb begin
        capIdx = 2'd0;
        case (capBit)
            4'b0010: capIdx = 2'd1;
            4'b0100: capIdx = 2'd2;
            4'b1000: capIdx = 2'd3;
            default: capIdx = 2'd0;
        endcase
    end

    always_comb begin
        decNib   = 4'hF;
        decBlank = 1'b0;
        decErr   = 1'b0;
        case (seg_q)
            7'b1000000: decNib = 4'd0;
            7'b1111001: decNib = 4'd1;
            7'b0100100: decNib = 4'd2;
            7'b0110000: decNib = 4'd3;
            7'b0011001: decNib = 4'd4;
            7'b0010010: decNib = 4'd5;
            7'b0000010: decNib = 4'd6;
            7'b1111000: decNib = 4'd7;
            7'b0000000: decNib = 4'd8;
            7'b0010000: decNib = 4'd9;
            7'b1111111: decBlank = 1'b1;
            default:    decErr = 1'b1;
        endcase
    end

    // Blank and error digits are stored as F and weigh zero in the binary value.
    assign convNib   = shadowNib_q[{idx_q, 2'b00} +: 4];
    assign convDigit = (convNib > 4'd9) ? 4'd0 : convNib;
    assign acc_d     = 14'(acc_q * 14'd10) + 14'(convDigit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= COLLECT;
            seg_q         <= '0;
            segPrev_q     <= '0;
            an_q          <= '0;
            anPrev_q      <= '0;
            stableCnt_q   <= '0;
            mask_q        <= '0;
            errFlag_q     <= 1'b0;
            convErr_q     <= 1'b0;
            timer_q       <= '0;
            shadowNib_q   <= '0;
            shadowBlank_q <= '0;
            acc_q         <= '0;
            idx_q         <= '0;
            digits_q      <= '0;
            blank_q       <= '0;
            value_q       <= '0;
            frameValid_q  <= 1'b0;
            segErr_q      <= 1'b0;
        end else begin
            seg_q        <= seg_n;
            an_q         <= an_n;
            segPrev_q    <= seg_q;
            anPrev_q     <= an_q;
            stableCnt_q  <= stableCnt_d;
            frameValid_q <= 1'b0;

            if (capture) begin
                shadowNib_q[{capIdx, 2'b00} +: 4] <= decNib;
                shadowBlank_q[capIdx]             <= decBlank;
            end

            case (state_q)
                COLLECT: begin
                    if (capture && maskNext == 4'hF) begin
                        state_q   <= CONVERT;
                        mask_q    <= '0;
                        errFlag_q <= 1'b0;
                        convErr_q <= errFlag_q | decErr;
                        timer_q   <= '0;
                        acc_q     <= '0;
                        idx_q     <= 2'd3;
                    end else if (capture) begin
                        mask_q    <= maskNext;
                        errFlag_q <= errFlag_q | decErr;
                        timer_q   <= '0;
                    end else if (mask_q != 4'h0) begin
                        if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                            mask_q    <= '0;
                            errFlag_q <= 1'b0;
                            timer_q   <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q - 2'd1;
                    if (idx_q == 2'd0) begin
                        digits_q     <= shadowNib_q;
                        blank_q      <= shadowBlank_q;
                        value_q      <= acc_d;
                        segErr_q     <= convErr_q;
                        frameValid_q <= 1'b1;
                        state_q      <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign digits      = digits_q;
    assign blank       = blank_q;
    assign value       = value_q;
    assign frame_valid = frameValid_q;
    assign seg_err     = segErr_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: scans hand-chosen digit frames and
// compares the decoded outputs against hand-computed values.
module tb_seg7_scan_reader;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SX = 7'b0101010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [13:0] value;
    logic        frame_valid;
    logic        seg_err;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    int framesBefore;
    int lat;

    seg7_scan_reader #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
        .digits(digits), .blank(blank), .value(value),
        .frame_valid(frame_valid), .seg_err(seg_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) frames++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        an_n  = 4'b1111;
        seg_n = SB;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int k, input logic [6:0] seg, input int hold);
        an_n  = ~(4'b0001 << k);
        seg_n = seg;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Digit 3 first; returns the number of edges from driving digit 0 until frame_valid is seen.
    task automatic scanFrame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                             input logic [6:0] s0, input int hold, output int latency);
        applyStimulus(3, s3, hold);
        applyStimulus(2, s2, hold);
        applyStimulus(1, s1, hold);
        an_n    = 4'b1110;
        seg_n   = s0;
        latency = -1;
        for (int i = 1; i <= hold + 12; i++) begin
            @(posedge clk);
            #1;
            if (frame_valid && latency < 0) latency = i;
            if (i == hold) begin
                an_n  = 4'b1111;
                seg_n = SB;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        an_n  = 4'b1111;
        seg_n = SB;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_digits", 32'(digits), 32'h0);
        checkOutput("rst_value", 32'(value), 32'd0);
        checkOutput("rst_blank", 32'(blank), 32'h0);
        checkOutput("rst_valid", 32'(frame_valid), 32'd0);
        checkOutput("rst_err", 32'(seg_err), 32'd0);
        rst_n = 1'b1;
        idle(3);

        framesBefore = frames;
        scanFrame(S1, S2, S3, S4, 6, lat);
        checkOutput("f1234_count", 32'(frames - framesBefore), 32'd1);
        checkOutput("f1234_latency", 32'(lat), 32'd9);
        checkOutput("f1234_digits", 32'(digits), 32'h1234);
        checkOutput("f1234_value", 32'(value), 32'd1234);
        checkOutput("f1234_blank", 32'(blank), 32'h0);
        checkOutput("f1234_err", 32'(seg_err), 32'd0);

        scanFrame(S5, S6, S7, S8, 6, lat);
        checkOutput("f5678_digits", 32'(digits), 32'h5678);
        checkOutput("f5678_value", 32'(value), 32'd5678);

        framesBefore = frames;
        for (int r = 0; r < 2; r++) begin
            applyStimulus(3, S1, 3);
            applyStimulus(2, S2, 3);
            applyStimulus(1, S3, 3);
            applyStimulus(0, S4, 3);
        end
        idle(12);
        checkOutput("short_hold_count", 32'(frames - framesBefore), 32'd0);
        checkOutput("short_hold_digits", 32'(digits), 32'h5678);

        scanFrame(SB, S0, S5, S9, 6, lat);
        checkOutput("fblank_digits", 32'(digits), 32'hF059);
        checkOutput("fblank_blank", 32'(blank), 32'h8);
        checkOutput("fblank_value", 32'(value), 32'd59);
        checkOutput("fblank_err", 32'(seg_err), 32'd0);

        scanFrame(S9, S9, SX, S9, 6, lat);
        checkOutput("ferr_err", 32'(seg_err), 32'd1);
        checkOutput("ferr_digits", 32'(digits), 32'h99F9);
        checkOutput("ferr_value", 32'(value), 32'd9909);
        checkOutput("ferr_blank", 32'(blank), 32'h0);
        scanFrame(S1, S2, S3, S4, 6, lat);
        checkOutput("fclean_err", 32'(seg_err), 32'd0);

        framesBefore = frames;
        applyStimulus(0, S1, 6);
        applyStimulus(1, S1, 6);
        applyStimulus(2, S1, 6);
        idle(120);
        checkOutput("timeout_nopulse", 32'(frames - framesBefore), 32'd0);
        scanFrame(S8, S8, S8, S8, 6, lat);
        checkOutput("timeout_count", 32'(frames - framesBefore), 32'd1);
        checkOutput("timeout_value", 32'(value), 32'd8888);

        framesBefore = frames;
        applyStimulus(1, S1, 6);
        applyStimulus(0, S2, 6);
        an_n  = 4'b0011;
        seg_n = S0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        checkOutput("badan_count", 32'(frames - framesBefore), 32'd0);
        applyStimulus(3, S3, 6);
        applyStimulus(2, S4, 6);
        rst_n = 1'b0;
        an_n  = 4'b1111;
        seg_n = SB;
        #1;
        checkOutput("midconv_rst_digits", 32'(digits), 32'h0);
        checkOutput("midconv_rst_value", 32'(value), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        checkOutput("midconv_count", 32'(frames - framesBefore), 32'd0);
        checkOutput("midconv_digits", 32'(digits), 32'h0);
        checkOutput("midconv_value", 32'(value), 32'd0);
        checkOutput("midconv_err", 32'(seg_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
